// File: rtl/cb_collector.sv
// cb_collector -- serial-to-parallel frame collector.
//
// Collects eight accepted serial words into one frame and presents the frame
// in parallel on Q0..Q7, with Q0 holding the first word received. A separate
// output bank holds the presented frame, so the next frame can be collected
// while the current one waits for the consumer. If a second frame completes
// while the bank is still occupied, the block stalls its input until the
// consumer takes the presented frame.
//
// Optional feature (macro CB_COLLECTOR_FRAME_CNT_EN): adds a 16-bit frame_cnt
// output counting out_valid&out_ready handshakes (wraps 65535->0).
//
// Ports:
//   clk        in   clock, all state changes on the rising edge
//   rst        in   synchronous reset, active-low
//   in_valid   in   a serial word is offered on in_data
//   in_data    in   serial sample word, DATA_WIDTH bits
//   in_ready   out  the block accepts in_data this cycle (decoded from state)
//   Q0..Q7     out  parallel frame, Q0 = first word received
//   out_valid  out  Q0..Q7 hold a complete frame
//   out_ready  in   downstream consumer takes the frame
//   frame_cnt  out  handshake count (only with CB_COLLECTOR_FRAME_CNT_EN)

module cb_collector #(
    parameter int DATA_WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  in_valid,
    input  logic [DATA_WIDTH-1:0] in_data,
    output logic                  in_ready,
    output logic [DATA_WIDTH-1:0] Q0,
    output logic [DATA_WIDTH-1:0] Q1,
    output logic [DATA_WIDTH-1:0] Q2,
    output logic [DATA_WIDTH-1:0] Q3,
    output logic [DATA_WIDTH-1:0] Q4,
    output logic [DATA_WIDTH-1:0] Q5,
    output logic [DATA_WIDTH-1:0] Q6,
    output logic [DATA_WIDTH-1:0] Q7,
    output logic                  out_valid,
    input  logic                  out_ready
`ifdef CB_COLLECTOR_FRAME_CNT_EN
    ,
    output logic [15:0]           frame_cnt
`endif
);

    typedef enum logic {
        COLLECT = 1'b0,
        STALL   = 1'b1
    } state_t;

    typedef logic [DATA_WIDTH-1:0] word_t;

    state_t     state_q, state_d;
    logic [2:0] wcnt_q, wcnt_d;
    word_t      col_q  [8];
    word_t      col_d  [8];
    word_t      bank_q [8];
    word_t      bank_d [8];
    logic       out_valid_q, out_valid_d;

    logic       accept;
    logic       consume;
    logic       xfer;

    // in_ready depends on the state register only, never on out_ready.
    assign in_ready = (state_q == COLLECT);
    assign accept   = in_valid & in_ready;
    assign consume  = out_valid_q & out_ready;

    always_comb begin
        state_d     = state_q;
        wcnt_d      = wcnt_q;
        col_d       = col_q;
        bank_d      = bank_q;
        out_valid_d = out_valid_q;
        xfer        = 1'b0;

        if (accept) begin
            // New word enters at stage 7; after eight shifts the first word
            // of the frame sits in stage 0.
            for (int i = 0; i < 7; i++) begin
                col_d[i] = col_q[i+1];
            end
            col_d[7] = in_data;
            wcnt_d   = wcnt_q + 3'd1;

            if (wcnt_q == 3'd7) begin
                // Bank is free if empty or being emptied at this same edge.
                if (!out_valid_q || out_ready) begin
                    bank_d = col_d;
                    xfer   = 1'b1;
                end else begin
                    // Full frame stays parked in the collection register.
                    state_d = STALL;
                end
            end
        end

        if (state_q == STALL && out_ready) begin
            bank_d  = col_q;
            xfer    = 1'b1;
            state_d = COLLECT;
        end

        // A transfer refills the bank in the same edge it is consumed, so
        // out_valid only drops when a handshake has nothing replacing it.
        if (xfer) begin
            out_valid_d = 1'b1;
        end else if (consume) begin
            out_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q     <= COLLECT;
            wcnt_q      <= 3'd0;
            out_valid_q <= 1'b0;
            for (int i = 0; i < 8; i++) begin
                col_q[i]  <= '0;
                bank_q[i] <= '0;
            end
        end else begin
            state_q     <= state_d;
            wcnt_q      <= wcnt_d;
            out_valid_q <= out_valid_d;
            col_q       <= col_d;
            bank_q      <= bank_d;
        end
    end

`ifdef CB_COLLECTOR_FRAME_CNT_EN
    logic [15:0] frame_cnt_q;

    always_ff @(posedge clk) begin
        if (!rst) begin
            frame_cnt_q <= 16'd0;
        end else if (consume) begin
            frame_cnt_q <= frame_cnt_q + 16'd1;
        end
    end

    assign frame_cnt = frame_cnt_q;
`endif

    assign out_valid = out_valid_q;
    assign Q0 = bank_q[0];
    assign Q1 = bank_q[1];
    assign Q2 = bank_q[2];
    assign Q3 = bank_q[3];
    assign Q4 = bank_q[4];
    assign Q5 = bank_q[5];
    assign Q6 = bank_q[6];
    assign Q7 = bank_q[7];

endmodule

// File: tb/tb_cb_collector.sv
// Self-checking bench for cb_collector: directed scenarios plus a random
// phase, checked by a scoreboard of expected frames and a reference model
// that tracks how many completed frames the block should be holding.

module tb_cb_collector;

    localparam int DW = 32;
    localparam int FW = 8 * DW;

    typedef logic [DW-1:0] word_t;
    typedef logic [FW-1:0] frame_t;

    logic    clk = 1'b0;
    logic    rst = 1'b0;
    logic    in_valid = 1'b0;
    word_t   in_data = '0;
    logic    in_ready;
    word_t   Q0, Q1, Q2, Q3, Q4, Q5, Q6, Q7;
    logic    out_valid;
    logic    out_ready = 1'b0;
`ifdef CB_COLLECTOR_FRAME_CNT_EN
    logic [15:0] frame_cnt;
`endif

    cb_collector #(.DATA_WIDTH(DW)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_data   (in_data),
        .in_ready  (in_ready),
        .Q0        (Q0),
        .Q1        (Q1),
        .Q2        (Q2),
        .Q3        (Q3),
        .Q4        (Q4),
        .Q5        (Q5),
        .Q6        (Q6),
        .Q7        (Q7),
        .out_valid (out_valid),
        .out_ready (out_ready)
`ifdef CB_COLLECTOR_FRAME_CNT_EN
        ,
        .frame_cnt (frame_cnt)
`endif
    );

    always #5 clk = ~clk;

    int     total = 0;
    int     bad = 0;
    frame_t exp_q[$];
    word_t  part_q[$];
    int     held = 0;
    bit     rst_seen = 1'b0;
    bit     rand_ordy = 1'b0;
    bit     stab_pending = 1'b0;
    frame_t stab_val;
`ifdef CB_COLLECTOR_FRAME_CNT_EN
    logic [15:0] fc_model = 16'd0;
`endif

    task automatic chk(input string nm, input frame_t act, input frame_t exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h, want %0h", nm, act, exp);
        end
    endtask

    function automatic frame_t cur_frame();
        return {Q7, Q6, Q5, Q4, Q3, Q2, Q1, Q0};
    endfunction

    // Reference model: a frame is every eight accepted words (first word in
    // the lowest slot); the block can hold at most two completed frames
    // (one presented, one parked), so input stalls exactly when two are held.
    always @(negedge clk) begin
        if (!rst) begin
            part_q.delete();
            exp_q.delete();
            held = 0;
            rst_seen = 1'b1;
`ifdef CB_COLLECTOR_FRAME_CNT_EN
            fc_model = 16'd0;
`endif
        end else begin
            if (rst_seen) begin
                chk("reset_q", cur_frame(), '0);
            end
            rst_seen = 1'b0;
            chk("in_ready", FW'(in_ready), FW'(held < 2));
            chk("out_valid", FW'(out_valid), FW'(held > 0));
`ifdef CB_COLLECTOR_FRAME_CNT_EN
            chk("frame_cnt", FW'(frame_cnt), FW'(fc_model));
            if (out_valid && out_ready) fc_model = fc_model + 16'd1;
`endif
            if (in_valid && in_ready) begin
                part_q.push_back(in_data);
                if (part_q.size() == 8) begin
                    frame_t f;
                    for (int i = 0; i < 8; i++) f[i*DW +: DW] = part_q[i];
                    exp_q.push_back(f);
                    part_q.delete();
                    held++;
                end
            end
            if (out_valid && out_ready) held--;
        end
    end

    // Monitor: pops the expected frame on each output handshake and checks
    // that a presented but unconsumed frame does not change.
    always @(negedge clk) begin
        if (rst) begin
            if (stab_pending) chk("q_stable", cur_frame(), stab_val);
            stab_pending = 1'b0;
            if (out_valid && out_ready) begin
                if (exp_q.size() == 0) begin
                    total++;
                    bad++;
                    $display("FAIL unexpected_frame: got %0h, want none", cur_frame());
                end else begin
                    chk("frame", cur_frame(), exp_q.pop_front());
                end
            end else if (out_valid) begin
                stab_pending = 1'b1;
                stab_val = cur_frame();
            end
        end else begin
            stab_pending = 1'b0;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
        if (rand_ordy) out_ready = 1'($urandom_range(0, 1));
    endtask

    task automatic send(input word_t w);
        bit acc = 1'b0;
        in_valid = 1'b1;
        in_data = w;
        for (int n = 0; n < 500 && !acc; n++) begin
            @(negedge clk);
            acc = in_ready;
            tick();
        end
        in_valid = 1'b0;
        if (!acc) begin
            total++;
            bad++;
            $display("FAIL send_timeout: got no accept, want accept of %0h", w);
        end
    endtask

    task automatic idle(input int n);
        in_valid = 1'b0;
        for (int i = 0; i < n; i++) tick();
    endtask

    initial begin
        rst = 1'b0;
        repeat (3) tick();
        rst = 1'b1;

        // Back-to-back frame with consumer always ready.
        out_ready = 1'b1;
        for (int i = 1; i <= 8; i++) send(word_t'(i));
        @(negedge clk);
        chk("t1_q0", FW'(Q0), FW'(1));
        chk("t1_q7", FW'(Q7), FW'(8));
        idle(3);

        // Consumer stalled across two frames, then released for one cycle.
        out_ready = 1'b0;
        for (int i = 1; i <= 16; i++) send(word_t'(i));
        @(negedge clk);
        chk("t2_stall_rdy", FW'(in_ready), FW'(0));
        chk("t2_q0_first", FW'(Q0), FW'(1));
        chk("t2_q7_first", FW'(Q7), FW'(8));
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        @(negedge clk);
        chk("t2_q0_second", FW'(Q0), FW'(9));
        chk("t2_q7_second", FW'(Q7), FW'(16));
        chk("t2_valid", FW'(out_valid), FW'(1));
        chk("t2_rdy_back", FW'(in_ready), FW'(1));
        out_ready = 1'b1;
        idle(3);

        // Gaps between words.
        for (int i = 0; i < 8; i++) begin
            send(word_t'(32'hA0 + i));
            idle(1);
        end
        @(negedge clk);
        chk("t3_q0", FW'(Q0), FW'(32'hA0));
        chk("t3_q7", FW'(Q7), FW'(32'hA7));
        idle(3);

        // Reset in the middle of a frame discards it.
        for (int i = 0; i < 5; i++) send(word_t'(32'hDEAD0 + i));
        rst = 1'b0;
        tick();
        rst = 1'b1;
        for (int i = 0; i < 8; i++) send(word_t'(32'h10 + i));
        @(negedge clk);
        chk("t4_q0", FW'(Q0), FW'(32'h10));
        chk("t4_q7", FW'(Q7), FW'(32'h17));
        idle(3);

        // Consume the presented frame on the same edge as the next frame's
        // eighth word.
        out_ready = 1'b0;
        for (int i = 0; i < 8; i++) send(word_t'(32'h100 + i));
        for (int i = 0; i < 7; i++) send(word_t'(32'h200 + i));
        out_ready = 1'b1;
        send(word_t'(32'h207));
        out_ready = 1'b0;
        @(negedge clk);
        chk("t5_valid", FW'(out_valid), FW'(1));
        chk("t5_q0", FW'(Q0), FW'(32'h200));
        chk("t5_q7", FW'(Q7), FW'(32'h207));
        out_ready = 1'b1;
        idle(3);

        // Random traffic with random backpressure.
        rand_ordy = 1'b1;
        for (int i = 0; i < 400; i++) begin
            send(DW'($urandom()));
            if ($urandom_range(0, 3) == 0) idle(int'($urandom_range(1, 3)));
        end
        rand_ordy = 1'b0;
        out_ready = 1'b1;
        idle(6);
        chk("drain_empty", FW'(exp_q.size()), FW'(0));

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
